election_controller: RTL and testbench

ELECTION_CONTROLLER -- requirements
Module: election_controller

---
 rtl/election_controller_if.sv | 54 +++++
 rtl/election_controller.sv | 211 +++++++++++++++++++++
 tb/tb_election_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/election_controller_if.sv
// election_controller_if
//   Request/response bundle for election_controller.
//   master : testbench or host side, drives the request and reads results.
//   slave  : the controller, reads the request and drives results.
//   Request  : req, mode[1:0], userID, candidate
//   Response : ballotBoxId, numberOfRegisteredVoters, numberOfVotesWinner,
//              WinnerId, phase[1:0], resultValid, Tie and six status pulses
//              (AlreadyRegistered, AlreadyVoted, NotRegistered,
//              VotingHasNotStarted, RegistrationHasEnded, VotingHasEnded).
interface election_controller_if #(
  parameter int N_VOTERS = 64,
  parameter int N_CAND   = 4,
  parameter int N_BOXES  = 4
);
  localparam int ID_W   = $clog2(N_VOTERS);
  localparam int CAND_W = $clog2(N_CAND);
  localparam int BOX_W  = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
  localparam int CNT_W  = $clog2(N_VOTERS + 1);

  logic              req;
  logic [1:0]        mode;
  logic [ID_W-1:0]   userID;
  logic [CAND_W-1:0] candidate;

  logic [BOX_W-1:0]  ballotBoxId;
  logic [CNT_W-1:0]  numberOfRegisteredVoters;
  logic [CNT_W-1:0]  numberOfVotesWinner;
  logic [CAND_W-1:0] WinnerId;
  logic [1:0]        phase;
  logic              resultValid;
  logic              Tie;
  logic              AlreadyRegistered;
  logic              AlreadyVoted;
  logic              NotRegistered;
  logic              VotingHasNotStarted;
  logic              RegistrationHasEnded;
  logic              VotingHasEnded;

  modport master (
    output req, mode, userID, candidate,
    input  ballotBoxId, numberOfRegisteredVoters, numberOfVotesWinner,
           WinnerId, phase, resultValid, Tie, AlreadyRegistered,
           AlreadyVoted, NotRegistered, VotingHasNotStarted,
           RegistrationHasEnded, VotingHasEnded
  );

  modport slave (
    input  req, mode, userID, candidate,
    output ballotBoxId, numberOfRegisteredVoters, numberOfVotesWinner,
           WinnerId, phase, resultValid, Tie, AlreadyRegistered,
           AlreadyVoted, NotRegistered, VotingHasNotStarted,
           RegistrationHasEnded, VotingHasEnded
  );
endinterface

// File: rtl/election_controller.sv
// election_controller
//   Runs a single election: a timed REGISTER phase, a timed VOTE phase, a
//   TALLY scan over all candidates (one per clock), then a terminal DONE
//   state holding the result until reset.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all progress and outputs
//   bus : election_controller_if.slave request/response bundle
//   Every output is a register; the response to a request sampled at edge k
//   is visible for the one cycle following edge k.
module election_controller #(
  parameter int N_VOTERS    = 64,
  parameter int N_CAND      = 4,
  parameter int N_BOXES     = 4,
  parameter int REG_CYCLES  = 100,
  parameter int VOTE_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  election_controller_if.slave bus
);
  localparam int ID_W   = $clog2(N_VOTERS);
  localparam int CAND_W = $clog2(N_CAND);
  localparam int BOX_W  = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
  localparam int CNT_W  = $clog2(N_VOTERS + 1);

  // The phase counter is shared by REGISTER, VOTE and the TALLY scan index,
  // so it is sized for the longest of the three.
  localparam int MAX_A  = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
  localparam int MAX_C  = (MAX_A > N_CAND) ? MAX_A : N_CAND;
  localparam int PH_W   = $clog2(MAX_C + 1);

  // Bit positions of the one-hot status pulse vector.
  localparam int S_AR  = 5;
  localparam int S_AV  = 4;
  localparam int S_NR  = 3;
  localparam int S_VNS = 2;
  localparam int S_RHE = 1;
  localparam int S_VHE = 0;

  typedef enum logic [1:0] {
    PH_REGISTER = 2'b00,
    PH_VOTE     = 2'b01,
    PH_TALLY    = 2'b10,
    PH_DONE     = 2'b11
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [PH_W-1:0]   cnt_q, cnt_d;

  logic [N_VOTERS-1:0] registered_q;
  logic [N_VOTERS-1:0] voted_q;
  logic [CNT_W-1:0]    votes_q [N_CAND];
  logic [CNT_W-1:0]    reg_count_q;

  logic [BOX_W-1:0]  box_q, box_d;
  logic [5:0]        status_q, status_d;
  logic [CNT_W-1:0]  win_votes_q;
  logic [CAND_W-1:0] win_id_q;
  logic              tie_q;
  logic              result_valid_q;

  logic              do_register;
  logic              do_vote;
  logic [CAND_W-1:0] scan_idx;
  logic [CNT_W-1:0]  scan_cnt;

  // Phase state register; the cycle counter doubles as the tally index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_REGISTER;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase sequencing: time advances every clock regardless of requests.
  // DONE is terminal, only reset leaves it.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      PH_REGISTER: begin
        if (cnt_q == PH_W'(REG_CYCLES - 1)) begin
          phase_d = PH_VOTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      PH_VOTE: begin
        if (cnt_q == PH_W'(VOTE_CYCLES - 1)) begin
          phase_d = PH_TALLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      PH_TALLY: begin
        if (cnt_q == PH_W'(N_CAND - 1)) begin
          phase_d = PH_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      default: begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
      end
    endcase
  end

  // Request decode. Modes 10/11 and idle cycles are not qualifying events,
  // so ballotBoxId and every pulse fall back to zero on those edges.
  always_comb begin
    box_d       = '0;
    status_d    = '0;
    do_register = 1'b0;
    do_vote     = 1'b0;
    if (bus.req && !bus.mode[1]) begin
      box_d = bus.userID[ID_W-1 -: BOX_W];
      case (phase_q)
        PH_REGISTER: begin
          if (bus.mode[0]) begin
            status_d[S_VNS] = 1'b1;
          end else if (registered_q[bus.userID]) begin
            status_d[S_AR] = 1'b1;
          end else begin
            do_register = 1'b1;
          end
        end
        PH_VOTE: begin
          if (!bus.mode[0]) begin
            status_d[S_RHE] = 1'b1;
          end else if (!registered_q[bus.userID]) begin
            status_d[S_NR] = 1'b1;
          end else if (voted_q[bus.userID]) begin
            status_d[S_AV] = 1'b1;
          end else begin
            do_vote = 1'b1;
          end
        end
        default: begin
          status_d[S_VHE] = 1'b1;
        end
      endcase
    end
  end

  assign scan_idx = cnt_q[CAND_W-1:0];
  assign scan_cnt = votes_q[scan_idx];

  // Voter bookkeeping, tally scan and output registers. The scan keeps the
  // first candidate reaching the best count, so ties resolve to the lowest
  // index; a tie is only flagged for a nonzero shared count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      registered_q   <= '0;
      voted_q        <= '0;
      reg_count_q    <= '0;
      for (int i = 0; i < N_CAND; i++) begin
        votes_q[i] <= '0;
      end
      box_q          <= '0;
      status_q       <= '0;
      win_votes_q    <= '0;
      win_id_q       <= '0;
      tie_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      box_q    <= box_d;
      status_q <= status_d;
      if (do_register) begin
        registered_q[bus.userID] <= 1'b1;
        reg_count_q              <= reg_count_q + CNT_W'(1);
      end
      if (do_vote) begin
        voted_q[bus.userID]    <= 1'b1;
        votes_q[bus.candidate] <= votes_q[bus.candidate] + CNT_W'(1);
      end
      if (phase_q == PH_TALLY) begin
        if (scan_cnt > win_votes_q) begin
          win_votes_q <= scan_cnt;
          win_id_q    <= scan_idx;
          tie_q       <= 1'b0;
        end else if ((scan_cnt == win_votes_q) && (scan_cnt != '0)) begin
          tie_q <= 1'b1;
        end
        if (phase_d == PH_DONE) begin
          result_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ballotBoxId              = box_q;
  assign bus.numberOfRegisteredVoters = reg_count_q;
  assign bus.numberOfVotesWinner      = win_votes_q;
  assign bus.WinnerId                 = win_id_q;
  assign bus.phase                    = phase_q;
  assign bus.resultValid              = result_valid_q;
  assign bus.Tie                      = tie_q;
  assign bus.AlreadyRegistered        = status_q[S_AR];
  assign bus.AlreadyVoted             = status_q[S_AV];
  assign bus.NotRegistered            = status_q[S_NR];
  assign bus.VotingHasNotStarted      = status_q[S_VNS];
  assign bus.RegistrationHasEnded     = status_q[S_RHE];
  assign bus.VotingHasEnded           = status_q[S_VHE];
endmodule

// File: tb/tb_election_controller.sv
// tb_election_controller
//   Directed self-checking bench for election_controller with 8 voters,
//   4 candidates, 2 ballot boxes, 4 registration and 6 voting cycles.
module tb_election_controller;
  localparam int N_VOTERS    = 8;
  localparam int N_CAND      = 4;
  localparam int N_BOXES     = 2;
  localparam int REG_CYCLES  = 4;
  localparam int VOTE_CYCLES = 6;

  // Pulse vector order: {AR, AV, NR, VHNS, RHE, VHE}
  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_AR   = 6'b100000;
  localparam logic [5:0] P_AV   = 6'b010000;
  localparam logic [5:0] P_NR   = 6'b001000;
  localparam logic [5:0] P_VNS  = 6'b000100;
  localparam logic [5:0] P_RHE  = 6'b000010;
  localparam logic [5:0] P_VHE  = 6'b000001;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [5:0] pulses;

  election_controller_if #(
    .N_VOTERS(N_VOTERS), .N_CAND(N_CAND), .N_BOXES(N_BOXES)
  ) bus ();

  election_controller #(
    .N_VOTERS(N_VOTERS), .N_CAND(N_CAND), .N_BOXES(N_BOXES),
    .REG_CYCLES(REG_CYCLES), .VOTE_CYCLES(VOTE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  assign pulses = {bus.AlreadyRegistered, bus.AlreadyVoted, bus.NotRegistered,
                   bus.VotingHasNotStarted, bus.RegistrationHasEnded,
                   bus.VotingHasEnded};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive the request, let the edge happen, settle 1 time unit.
  task automatic applyStimulus(input logic r, input logic [1:0] m,
                               input int id, input int cand);
    bus.req       = r;
    bus.mode      = m;
    bus.userID    = 3'(id);
    bus.candidate = 2'(cand);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 0, 0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    bus.req = 1'b0; bus.mode = 2'b00; bus.userID = '0; bus.candidate = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    rst = 1'b0;
  endtask

  task automatic checkResp(input string tag, input logic [5:0] p,
                           input int box, input int cnt);
    checkOutput({tag, ".pulses"}, 32'(pulses), 32'(p));
    checkOutput({tag, ".box"}, 32'(bus.ballotBoxId), 32'(box));
    checkOutput({tag, ".regCount"}, 32'(bus.numberOfRegisteredVoters), 32'(cnt));
  endtask

  task automatic checkResult(input string tag, input int valid, input int win,
                             input int votes, input int tie);
    checkOutput({tag, ".valid"}, 32'(bus.resultValid), 32'(valid));
    checkOutput({tag, ".winner"}, 32'(bus.WinnerId), 32'(win));
    checkOutput({tag, ".votes"}, 32'(bus.numberOfVotesWinner), 32'(votes));
    checkOutput({tag, ".tie"}, 32'(bus.Tie), 32'(tie));
  endtask

  task automatic checkPhase(input string tag, input int ph);
    checkOutput({tag, ".phase"}, 32'(bus.phase), 32'(ph));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Run 1: duplicate registration, out-of-phase requests, single vote.
    resetDut();
    checkResp("reset", P_NONE, 0, 0);
    checkResult("reset", 0, 0, 0, 0);
    checkPhase("reset", 0);
    releaseReset();
    applyStimulus(1'b1, 2'b00, 5, 0); checkResp("reg5", P_NONE, 1, 1);
    applyStimulus(1'b1, 2'b00, 5, 0); checkResp("reg5again", P_AR, 1, 1);
    applyStimulus(1'b1, 2'b01, 5, 0); checkResp("voteInReg", P_VNS, 1, 1);
    applyStimulus(1'b0, 2'b00, 0, 0); checkResp("idle", P_NONE, 0, 1);
    checkPhase("enterVote", 1);
    applyStimulus(1'b1, 2'b00, 2, 0); checkResp("regInVote", P_RHE, 0, 1);
    applyStimulus(1'b1, 2'b01, 5, 1); checkResp("vote5", P_NONE, 1, 1);
    applyStimulus(1'b1, 2'b01, 5, 2); checkResp("vote5again", P_AV, 1, 1);
    idleCycles(3);
    checkPhase("enterTally", 2);
    checkResult("tallyStart", 0, 0, 0, 0);
    idleCycles(3);
    checkResult("tallyMid", 0, 1, 1, 0);
    idleCycles(1);
    checkResult("run1Done", 1, 1, 1, 0);
    checkPhase("run1Done", 3);
    applyStimulus(1'b1, 2'b01, 7, 0); checkResp("reqInDone", P_VHE, 1, 1);
    applyStimulus(1'b1, 2'b10, 7, 0); checkResp("noopInDone", P_NONE, 0, 1);
    checkPhase("doneHolds", 3);

    // Run 2: clear winner with duplicate and unregistered voters.
    resetDut();
    releaseReset();
    applyStimulus(1'b1, 2'b00, 1, 0); checkResp("reg1", P_NONE, 0, 1);
    applyStimulus(1'b1, 2'b00, 2, 0); checkResp("reg2", P_NONE, 0, 2);
    applyStimulus(1'b1, 2'b00, 3, 0); checkResp("reg3", P_NONE, 0, 3);
    idleCycles(1);
    applyStimulus(1'b1, 2'b01, 1, 2); checkResp("v1c2", P_NONE, 0, 3);
    applyStimulus(1'b1, 2'b01, 2, 2); checkResp("v2c2", P_NONE, 0, 3);
    applyStimulus(1'b1, 2'b01, 3, 1); checkResp("v3c1", P_NONE, 0, 3);
    applyStimulus(1'b1, 2'b01, 1, 0); checkResp("v1c0", P_AV, 0, 3);
    applyStimulus(1'b1, 2'b01, 6, 3); checkResp("v6c3", P_NR, 1, 3);
    idleCycles(1);
    checkPhase("run2Tally", 2);
    idleCycles(4);
    checkResult("run2Done", 1, 2, 2, 0);

    // Run 3: two candidates share the top count.
    resetDut();
    releaseReset();
    applyStimulus(1'b1, 2'b00, 1, 0);
    applyStimulus(1'b1, 2'b00, 2, 0);
    idleCycles(2);
    applyStimulus(1'b1, 2'b01, 1, 1); checkResp("tieV1", P_NONE, 0, 2);
    applyStimulus(1'b1, 2'b01, 2, 3); checkResp("tieV2", P_NONE, 0, 2);
    idleCycles(8);
    checkResult("run3Done", 1, 1, 1, 1);

    // Run 4: no votes; result exactly four clocks after VOTE ends.
    resetDut();
    releaseReset();
    idleCycles(10);
    checkPhase("run4Tally", 2);
    idleCycles(3);
    checkResult("run4Tally3", 0, 0, 0, 0);
    idleCycles(1);
    checkResult("run4Done", 1, 0, 0, 0);
    checkPhase("run4Done", 3);
    idleCycles(5);
    checkPhase("run4Terminal", 3);
    checkOutput("run4Terminal.valid", 32'(bus.resultValid), 32'd1);

    // Run 5: asynchronous reset between edges in the middle of VOTE.
    resetDut();
    releaseReset();
    applyStimulus(1'b1, 2'b00, 4, 0); checkResp("reg4", P_NONE, 1, 1);
    idleCycles(3);
    applyStimulus(1'b1, 2'b01, 4, 0); checkResp("v4c0", P_NONE, 1, 1);
    #2 rst = 1'b1;
    #1;
    checkResp("asyncRst", P_NONE, 0, 0);
    checkPhase("asyncRst", 0);
    #2 rst = 1'b0;
    applyStimulus(1'b1, 2'b00, 4, 0); checkResp("reReg4", P_NONE, 1, 1);
    idleCycles(3);
    checkPhase("run5Vote", 1);
    idleCycles(10);
    checkResult("run5Done", 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
